// File: rtl/fir_out_buf.sv
// Output buffer behind the fir core's AXI-Stream master: a small FWFT FIFO that absorbs
// host back-pressure, plus tlast-vs-data_length checking and frame status.
module fir_out_buf #(
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned pDEPTH      = 8,
  parameter int unsigned pLVL_W      = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  input  logic [31:0]            cfg_data_length,
  input  logic                   clr,
  output logic [pLVL_W-1:0]      level,
  output logic [31:0]            sample_cnt,
  output logic                   frame_done,
  output logic                   tlast_err
);

  localparam int unsigned PtrW  = pLVL_W - 1;
  localparam int unsigned WordW = pDATA_WIDTH + 1;

  logic [WordW-1:0]  mem_q [pDEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [pLVL_W-1:0] level_q, level_d;
  logic              rst_hold_q;
  logic [31:0]       cnt_q, cnt_d, cnt_base;
  logic              frame_done_q, frame_done_d;
  logic              tlast_err_q, tlast_err_d;
  logic              push, pop, exp_last, len_chk;
  logic [WordW-1:0]  rd_word;

  // Ready is held low for the cycle following a reset edge.
  assign ss_tready = ~rst_hold_q & (level_q != pLVL_W'(pDEPTH));
  assign sm_tvalid = (level_q != '0);
  assign push      = ss_tvalid & ss_tready;
  assign pop       = sm_tvalid & sm_tready;

  assign rd_word   = sm_tvalid ? mem_q[rd_ptr_q] : '0;
  assign sm_tdata  = rd_word[pDATA_WIDTH-1:0];
  assign sm_tlast  = rd_word[pDATA_WIDTH];

  assign level      = level_q;
  assign sample_cnt = cnt_q;
  assign frame_done = frame_done_q;
  assign tlast_err  = tlast_err_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + pLVL_W'(1);
      2'b01:   level_d = level_q - pLVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // clr zeroes the status first; any set condition in the same cycle then applies on top.
  always_comb begin
    cnt_base     = clr ? '0 : cnt_q;
    len_chk      = (cfg_data_length != '0);
    exp_last     = len_chk && (cnt_base == cfg_data_length - 32'd1);
    cnt_d        = cnt_base;
    tlast_err_d  = clr ? 1'b0 : tlast_err_q;
    frame_done_d = clr ? 1'b0 : frame_done_q;
    if (push) begin
      cnt_d = (ss_tlast || exp_last) ? '0 : cnt_base + 32'd1;
      if (len_chk && (ss_tlast != exp_last)) tlast_err_d = 1'b1;
    end
    if (pop && sm_tlast) frame_done_d = 1'b1;
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      rst_hold_q   <= 1'b1;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      tlast_err_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      rst_hold_q   <= 1'b0;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      tlast_err_q  <= tlast_err_d;
    end
  end

  // Storage needs no reset: the pointers and level decide what is visible.
  always_ff @(posedge axis_clk) begin
    if (push) mem_q[wr_ptr_q] <= {ss_tlast, ss_tdata};
  end

endmodule

// File: tb/tb_fir_out_buf.sv
// Scoreboard bench for fir_out_buf: the driver queues each accepted beat, a negedge
// monitor compares every popped beat; status is checked at frame boundaries.
module tb_fir_out_buf;

  logic        axis_clk;
  logic        axis_rst;
  logic        ss_tvalid;
  logic [31:0] ss_tdata;
  logic        ss_tlast;
  logic        ss_tready;
  logic        sm_tvalid;
  logic [31:0] sm_tdata;
  logic        sm_tlast;
  logic        sm_tready;
  logic [31:0] cfg_data_length;
  logic        clr;
  logic [3:0]  level;
  logic [31:0] sample_cnt;
  logic        frame_done;
  logic        tlast_err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [32:0] exp_q [$];

  fir_out_buf #(
    .pDATA_WIDTH(32),
    .pDEPTH     (8),
    .pLVL_W     (4)
  ) dut (
    .axis_clk       (axis_clk),
    .axis_rst       (axis_rst),
    .ss_tvalid      (ss_tvalid),
    .ss_tdata       (ss_tdata),
    .ss_tlast       (ss_tlast),
    .ss_tready      (ss_tready),
    .sm_tvalid      (sm_tvalid),
    .sm_tdata       (sm_tdata),
    .sm_tlast       (sm_tlast),
    .sm_tready      (sm_tready),
    .cfg_data_length(cfg_data_length),
    .clr            (clr),
    .level          (level),
    .sample_cnt     (sample_cnt),
    .frame_done     (frame_done),
    .tlast_err      (tlast_err)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_checks++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: every beat leaving on sm_* must match the oldest queued beat.
  always @(negedge axis_clk) begin
    if (!axis_rst && sm_tvalid && sm_tready) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", {31'd0, sm_tlast, sm_tdata}, 64'h1_0000_0000_dead);
      end else begin
        check("pop_beat", {31'd0, sm_tlast, sm_tdata}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    bit done = 0;
    ss_tvalid = 1'b1;
    ss_tdata  = d;
    ss_tlast  = l;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge axis_clk);
      if (ss_tready) begin
        exp_q.push_back({l, d});
        done = 1;
      end
      @(posedge axis_clk);
      #1;
    end
    ss_tvalid = 1'b0;
    ss_tlast  = 1'b0;
    if (!done) timeout("send");
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge axis_clk);
      if (exp_q.size() == 0 && !sm_tvalid) done = 1;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_tvalid_low", sm_tvalid, 0);
    @(posedge axis_clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge axis_clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    axis_rst = 1'b1; ss_tvalid = 1'b0; ss_tdata = '0; ss_tlast = 1'b0;
    sm_tready = 1'b0; cfg_data_length = '0; clr = 1'b0;

    // 1: reset values, ready released one cycle after reset drops
    repeat (2) @(posedge axis_clk);
    @(negedge axis_clk);
    check("rst_ss_tready", ss_tready, 0);
    check("rst_sm_tvalid", sm_tvalid, 0);
    check("rst_sm_tdata", sm_tdata, 0);
    check("rst_level", level, 0);
    check("rst_status", {sample_cnt, frame_done, tlast_err}, 0);
    @(posedge axis_clk); #1; axis_rst = 1'b0;
    @(negedge axis_clk);
    check("rel_ss_tready_hold", ss_tready, 0);
    @(negedge axis_clk);
    check("rel_ss_tready", ss_tready, 1);
    @(posedge axis_clk); #1;

    // 2: L=4 frame, 1-cycle latency, no bypass
    cfg_data_length = 32'd4;
    sm_tready = 1'b1;
    ss_tvalid = 1'b1; ss_tdata = 32'd4; ss_tlast = 1'b0;
    @(negedge axis_clk);
    check("lat_push_ready", ss_tready, 1);
    check("lat_no_bypass", sm_tvalid, 0);
    exp_q.push_back({1'b0, 32'd4});
    @(posedge axis_clk); #1; ss_tvalid = 1'b0;
    @(negedge axis_clk);
    check("lat_valid", sm_tvalid, 1);
    check("lat_data", sm_tdata, 4);
    @(posedge axis_clk); #1;
    send(-32'sd3, 1'b0);
    send(32'd7, 1'b0);
    send(32'd100, 1'b1);
    drain();
    check("f2_frame_done", frame_done, 1);
    check("f2_tlast_err", tlast_err, 0);
    check("f2_sample_cnt", sample_cnt, 0);

    // 3: back-pressure, 10 beats into 8 entries
    pulse_clr();
    cfg_data_length = '0;
    sm_tready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h300 + i, 1'b0);
    @(negedge axis_clk);
    check("full_level", level, 8);
    check("full_ss_tready", ss_tready, 0);
    check("full_frame_done", frame_done, 0);
    @(posedge axis_clk); #1;
    fork
      begin
        send(32'h308, 1'b0);
        send(32'h309, 1'b0);
      end
      begin
        repeat (4) @(posedge axis_clk);
        #1 sm_tready = 1'b1;
      end
    join
    drain();

    // 4: full FIFO with continuous push/pop across pointer wrap
    sm_tready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h400 + i, 1'b0);
    sm_tready = 1'b1;
    ss_tvalid = 1'b1;
    ss_tdata  = 32'h408;
    for (int i = 0; i < 12; i++) begin
      @(negedge axis_clk);
      check("stream_level", level, (i == 0) ? 8 : 7);
      check("stream_ss_tready", ss_tready, (i == 0) ? 0 : 1);
      if (ss_tready) exp_q.push_back({1'b0, ss_tdata});
      @(posedge axis_clk); #1;
      if (i != 0) ss_tdata = ss_tdata + 32'd1;
    end
    ss_tvalid = 1'b0;
    drain();

    // 5: early tlast, then missing tlast, then clr; clr coinciding with an error
    pulse_clr();
    cfg_data_length = 32'd4;
    send(32'd11, 1'b0);
    send(32'd12, 1'b0);
    send(32'd13, 1'b1);
    drain();
    check("early_tlast_err", tlast_err, 1);
    check("early_sample_cnt", sample_cnt, 0);
    check("early_frame_done", frame_done, 1);
    for (int i = 0; i < 4; i++) send(32'd21 + i, 1'b0);
    drain();
    check("miss_tlast_err", tlast_err, 1);
    check("miss_sample_cnt", sample_cnt, 0);
    pulse_clr();
    @(negedge axis_clk);
    check("clr_tlast_err", tlast_err, 0);
    check("clr_frame_done", frame_done, 0);
    check("clr_sample_cnt", sample_cnt, 0);
    @(posedge axis_clk); #1;
    clr = 1'b1;
    send(32'd31, 1'b1);
    clr = 1'b0;
    @(negedge axis_clk);
    check("clr_vs_set_err", tlast_err, 1);
    @(posedge axis_clk); #1;
    drain();

    // 6: reset mid-frame, then a clean L-beat frame
    pulse_clr();
    cfg_data_length = 32'd8;
    sm_tready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'd41 + i, 1'b0);
    @(negedge axis_clk);
    check("mid_level", level, 5);
    check("mid_sample_cnt", sample_cnt, 5);
    @(posedge axis_clk); #1;
    axis_rst = 1'b1;
    @(posedge axis_clk); #1;
    axis_rst = 1'b0;
    exp_q.delete();
    @(negedge axis_clk);
    check("mrst_level", level, 0);
    check("mrst_sm_tvalid", sm_tvalid, 0);
    check("mrst_sample_cnt", sample_cnt, 0);
    check("mrst_ss_tready", ss_tready, 0);
    @(posedge axis_clk); #1;
    sm_tready = 1'b1;
    for (int i = 0; i < 8; i++) send(32'd51 + i, (i == 7));
    drain();
    check("post_tlast_err", tlast_err, 0);
    check("post_frame_done", frame_done, 1);
    check("post_sample_cnt", sample_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
